// File: rtl/sumador_pkg.sv
// sumador_pkg
// Types and helpers shared by the multi-cycle adder files.
//   state_t   : FSM state type, values taken from sumador_defs.vh
//   idx_width : width of the chunk index counter (at least 1 bit)
package sumador_pkg;

`include "sumador_defs.vh"

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sumador_bloque.sv
// sumador_bloque
// Combinational ripple-carry adder of CHUNK full-adder cells.
// Ports:
//   a, b     in  CHUNK  chunk operands
//   cin      in  1      carry into bit 0
//   s        out CHUNK  chunk sum
//   cout     out 1      carry out of the top bit
//   c_msb_in out 1      carry into the top bit (used for signed overflow)
module sumador_bloque #(
    parameter int CHUNK = 2
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
            assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/sumador_defs.vh
// sumador_defs.vh
// Shared definitions for the multi-cycle adder:
//   - FSM state encodings (S_IDLE, S_RUN, S_DONE)
//   - SUMADOR_CHECK_PARAMS(W, C): elaboration-time legality check of WIDTH/CHUNK
`ifndef SUMADOR_DEFS_VH
`define SUMADOR_DEFS_VH

localparam logic [1:0] S_IDLE = 2'd0;
localparam logic [1:0] S_RUN  = 2'd1;
localparam logic [1:0] S_DONE = 2'd2;

// Rejects a width/chunk pair that does not split the word into whole chunks.
`define SUMADOR_CHECK_PARAMS(W, C) \
    if (((W) < 1) || ((C) < 1) || ((C) > (W)) || (((W) % (C)) != 0)) begin : g_param_error \
        $error("sumador_multiciclo: illegal WIDTH/CHUNK combination"); \
    end

`endif

// File: rtl/sumador_multiciclo.sv
// sumador_multiciclo
// Multi-cycle adder: s = a + b + ci over WIDTH bits, CHUNK bits per clock,
// carry registered between chunks. start/busy/done handshake.
// Optional feature macro: SUMADOR_OVF_EN adds the signed-overflow output ovf.
// Ports:
//   clk   in  1      clock, rising edge
//   rst   in  1      asynchronous active-high reset
//   start in  1      request, accepted in IDLE or DONE
//   a, b  in  WIDTH  operands, captured with an accepted start
//   ci    in  1      carry in, captured with an accepted start
//   busy  out 1      high while chunks are being added
//   done  out 1      one-cycle pulse, s/co (and ovf) valid
//   s     out WIDTH  sum, held until the next completion
//   co    out 1      carry out of the MSB
//   ovf   out 1      signed overflow (SUMADOR_OVF_EN only)
`include "sumador_defs.vh"

module sumador_multiciclo
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef SUMADOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = idx_width(NCHUNK);

    `SUMADOR_CHECK_PARAMS(WIDTH, CHUNK)

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             carry_reg, carry_next;
    logic [WIDTH-1:0] op_a_reg, op_a_next;
    logic [WIDTH-1:0] op_b_reg, op_b_next;
    logic [WIDTH-1:0] acc_reg, acc_next;
    logic [WIDTH-1:0] s_reg, s_next;
    logic             co_reg, co_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [CHUNK-1:0] chunk_a, chunk_b, chunk_s;
    logic             chunk_cout;
    int               base;
    logic             last_chunk;

    assign base       = int'(idx_reg) * CHUNK;
    assign last_chunk = (int'(idx_reg) == NCHUNK - 1);
    assign chunk_a    = op_a_reg[base +: CHUNK];
    assign chunk_b    = op_b_reg[base +: CHUNK];

`ifdef SUMADOR_OVF_EN
    logic chunk_c_msb;
    logic ovf_reg, ovf_next;
`else
    logic unused_c_msb;
`endif

    sumador_bloque #(
        .CHUNK (CHUNK)
    ) u_bloque (
        .a        (chunk_a),
        .b        (chunk_b),
        .cin      (carry_reg),
        .s        (chunk_s),
        .cout     (chunk_cout),
`ifdef SUMADOR_OVF_EN
        .c_msb_in (chunk_c_msb)
`else
        .c_msb_in (unused_c_msb)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            acc_reg   <= '0;
            s_reg     <= '0;
            co_reg    <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            carry_reg <= carry_next;
            op_a_reg  <= op_a_next;
            op_b_reg  <= op_b_next;
            acc_reg   <= acc_next;
            s_reg     <= s_next;
            co_reg    <= co_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        carry_next = carry_reg;
        op_a_next  = op_a_reg;
        op_b_next  = op_b_reg;
        acc_next   = acc_reg;
        s_next     = s_reg;
        co_next    = co_reg;
`ifdef SUMADOR_OVF_EN
        ovf_next   = ovf_reg;
`endif

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // DONE accepts a new request exactly like IDLE, giving
                // one result every NCHUNK+1 cycles when start is held.
                if (start) begin
                    op_a_next  = a;
                    op_b_next  = b;
                    carry_next = ci;
                    idx_next   = '0;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                acc_next[base +: CHUNK] = chunk_s;
                carry_next              = chunk_cout;
                if (last_chunk) begin
                    // acc_next already includes the final chunk, so s never
                    // exposes a partial sum.
                    s_next     = acc_next;
                    co_next    = chunk_cout;
`ifdef SUMADOR_OVF_EN
                    ovf_next   = chunk_c_msb ^ chunk_cout;
`endif
                    idx_next   = '0;
                    state_next = ST_DONE;
                end else begin
                    idx_next   = idx_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        busy_next = (state_next == ST_RUN);
        done_next = (state_next == ST_DONE);
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign s    = s_reg;
    assign co   = co_reg;

`ifdef SUMADOR_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_sumador_multiciclo.sv
// tb_sumador_multiciclo
// Directed bench for sumador_multiciclo: an 8/2 instance for the handshake
// scenarios, a 1/1 instance for the full-adder truth table and a 16/4
// instance for wider vectors. Build with SUMADOR_OVF_EN to check ovf as well.
module tb_sumador_multiciclo;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // WIDTH=8, CHUNK=2
    logic       start8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, co8;
    logic [7:0] s8;
    // WIDTH=1, CHUNK=1
    logic       start1 = 1'b0, ci1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0;
    logic       busy1, done1, co1;
    logic [0:0] s1;
    // WIDTH=16, CHUNK=4
    logic        start16 = 1'b0, ci16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, co16;
    logic [15:0] s16;
`ifdef SUMADOR_OVF_EN
    logic ovf8, ovf1, ovf16;
`endif

    sumador_multiciclo #(.WIDTH(8), .CHUNK(2)) dut (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .ci(ci8),
        .busy(busy8), .done(done8), .s(s8), .co(co8)
`ifdef SUMADOR_OVF_EN
        , .ovf(ovf8)
`endif
    );

    sumador_multiciclo #(.WIDTH(1), .CHUNK(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .ci(ci1),
        .busy(busy1), .done(done1), .s(s1), .co(co1)
`ifdef SUMADOR_OVF_EN
        , .ovf(ovf1)
`endif
    );

    sumador_multiciclo #(.WIDTH(16), .CHUNK(4)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .ci(ci16),
        .busy(busy16), .done(done16), .s(s16), .co(co16)
`ifdef SUMADOR_OVF_EN
        , .ovf(ovf16)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit transaction: start for one cycle, then scramble the inputs.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v, input logic tci,
                        input logic [7:0] es, input logic eco, input logic eovf);
        int         done_at, busy_cnt, done_cnt;
        logic [7:0] s_before, s_done;
        logic       co_before, co_done, hold_bad, ovf_done;
        s_before = s8; co_before = co8;
        done_at = -1; busy_cnt = 0; done_cnt = 0; hold_bad = 1'b0;
        s_done = '0; co_done = 1'b0; ovf_done = 1'b0;
        a8 = ta; b8 = tb_v; ci8 = tci; start8 = 1'b1;
        tick();
        start8 = 1'b0; a8 = ~ta; b8 = ~tb_v; ci8 = ~tci;
        for (int i = 0; i < 10; i++) begin
            if (busy8) busy_cnt++;
            if (done8) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i; s_done = s8; co_done = co8;
`ifdef SUMADOR_OVF_EN
                    ovf_done = ovf8;
`endif
                end
            end else if (done_at < 0 && (s8 !== s_before || co8 !== co_before)) begin
                hold_bad = 1'b1;
            end
            tick();
        end
        $display("[TB] txn8 a=%h b=%h ci=%0d -> s=%h co=%0d ovf=%0d (exp %h %0d %0d) done_at=%0d",
                 ta, tb_v, tci, s_done, co_done, ovf_done, es, eco, eovf, done_at);
        tests_run++;
        if (s_done !== es) begin
            tests_failed++; $display("FAIL run8_s: got %h expected %h", s_done, es);
        end
        tests_run++;
        if (co_done !== eco) begin
            tests_failed++; $display("FAIL run8_co: got %0d expected %0d", co_done, eco);
        end
`ifdef SUMADOR_OVF_EN
        tests_run++;
        if (ovf_done !== eovf) begin
            tests_failed++; $display("FAIL run8_ovf: got %0d expected %0d", ovf_done, eovf);
        end
`endif
        tests_run++;
        if (done_at != 4) begin
            tests_failed++; $display("FAIL run8_latency: got %0d expected 4", done_at);
        end
        tests_run++;
        if (busy_cnt != 4 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL run8_handshake: busy=%0d done=%0d expected busy=4 done=1", busy_cnt, done_cnt);
        end
        tests_run++;
        if (hold_bad || s8 !== es) begin
            tests_failed++;
            $display("FAIL run8_hold: partial=%0d s_end=%h expected no change before done, s_end=%h",
                     hold_bad, s8, es);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        tests_run++;
        if ({busy8, done8, co8, s8} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset8: busy=%0d done=%0d co=%0d s=%h expected all 0", busy8, done8, co8, s8);
        end
        tests_run++;
        if ({busy16, done16, co16, s16} !== 19'd0 || {busy1, done1, co1, s1} !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_others: s16=%h co16=%0d s1=%0d co1=%0d expected 0", s16, co16, s1, co1);
        end
`ifdef SUMADOR_OVF_EN
        tests_run++;
        if ({ovf8, ovf1, ovf16} !== 3'b000) begin
            tests_failed++; $display("FAIL reset_ovf: got %b expected 000", {ovf8, ovf1, ovf16});
        end
`endif
        $display("[TB] reset s8=%h busy8=%0d done8=%0d", s8, busy8, done8);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run8(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        run8(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        run8(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        run8(8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0, 1'b0);
        run8(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        int         seen, first_at, second_at;
        logic [7:0] sa, sb;
        logic       ca, cb;
        seen = 0; first_at = -1; second_at = -1;
        sa = '0; sb = '0; ca = 1'b0; cb = 1'b0;
        a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
        tick();
        for (int i = 0; i < 14; i++) begin
            if (done8) begin
                seen++;
                if (seen == 1) begin
                    first_at = i; sa = s8; ca = co8;
                    a8 = 8'h20; b8 = 8'h05; ci8 = 1'b1;
                end else if (seen == 2) begin
                    second_at = i; sb = s8; cb = co8;
                    start8 = 1'b0;
                end
            end else if (start8) begin
                a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            end
            tick();
        end
        start8 = 1'b0;
        $display("[TB] b2b first s=%h@%0d second s=%h@%0d dones=%0d", sa, first_at, sb, second_at, seen);
        tests_run++;
        if (sa !== 8'h46 || ca !== 1'b0 || first_at != 4) begin
            tests_failed++;
            $display("FAIL b2b_first: s=%h co=%0d at=%0d expected s=46 co=0 at=4", sa, ca, first_at);
        end
        tests_run++;
        if (sb !== 8'h26 || cb !== 1'b0) begin
            tests_failed++; $display("FAIL b2b_second: s=%h co=%0d expected s=26 co=0", sb, cb);
        end
        tests_run++;
        if (second_at - first_at != 5 || seen != 2) begin
            tests_failed++;
            $display("FAIL b2b_spacing: gap=%0d dones=%0d expected gap=5 dones=2", second_at - first_at, seen);
        end
    endtask

    task automatic test_reset_mid_run();
        int stray;
        stray = 0;
        a8 = 8'hFF; b8 = 8'h01; ci8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        tests_run++;
        if ({busy8, done8, co8, s8} !== 11'd0) begin
            tests_failed++;
            $display("FAIL midrun_reset: busy=%0d done=%0d co=%0d s=%h expected all 0", busy8, done8, co8, s8);
        end
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done8 || busy8) stray++;
            tick();
        end
        $display("[TB] midrun reset stray=%0d s8=%h", stray, s8);
        tests_run++;
        if (stray != 0 || s8 !== 8'h00) begin
            tests_failed++; $display("FAIL midrun_no_done: stray=%0d s=%h expected 0 00", stray, s8);
        end
        run8(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
    endtask

    task automatic test_width1();
        logic       ta, tb_v, tci, es, eco, eovf, s_done, co_done, ovf_done;
        int         done_at, done_cnt, busy_cnt;
        logic [2:0] combo;
        for (int k = 0; k < 8; k++) begin
            combo = 3'(k);
            ta = combo[0]; tb_v = combo[1]; tci = combo[2];
            // Hand truth table of a full adder
            es   = ta ^ tb_v ^ tci;
            eco  = (ta & tb_v) | (ta & tci) | (tb_v & tci);
            eovf = (ta == tb_v) && (es != ta);
            a1 = ta; b1 = tb_v; ci1 = tci; start1 = 1'b1;
            tick();
            start1 = 1'b0;
            done_at = -1; done_cnt = 0; busy_cnt = 0;
            s_done = 1'b0; co_done = 1'b0; ovf_done = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (busy1) busy_cnt++;
                if (done1) begin
                    done_cnt++;
                    if (done_at < 0) begin
                        done_at = i; s_done = s1; co_done = co1;
`ifdef SUMADOR_OVF_EN
                        ovf_done = ovf1;
`endif
                    end
                end
                tick();
            end
            $display("[TB] txn1 ci=%0d b=%0d a=%0d -> co=%0d s=%0d ovf=%0d (exp %0d %0d %0d)",
                     tci, tb_v, ta, co_done, s_done, ovf_done, eco, es, eovf);
            tests_run++;
            if ({co_done, s_done} !== {eco, es}) begin
                tests_failed++;
                $display("FAIL w1_sum: combo=%0d got %b expected %b", k, {co_done, s_done}, {eco, es});
            end
            tests_run++;
            if (done_at != 1 || done_cnt != 1 || busy_cnt != 1) begin
                tests_failed++;
                $display("FAIL w1_timing: done_at=%0d dones=%0d busy=%0d expected 1 1 1",
                         done_at, done_cnt, busy_cnt);
            end
`ifdef SUMADOR_OVF_EN
            tests_run++;
            if (ovf_done !== eovf) begin
                tests_failed++; $display("FAIL w1_ovf: combo=%0d got %0d expected %0d", k, ovf_done, eovf);
            end
`endif
        end
    endtask

    task automatic run16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tci);
        logic [16:0] exp_sum;
        logic [15:0] s_done;
        logic        co_done, eovf, ovf_done;
        int          done_at, done_cnt;
        exp_sum = {1'b0, ta} + {1'b0, tb_v} + {16'd0, tci};
        eovf    = (ta[15] == tb_v[15]) && (exp_sum[15] != ta[15]);
        a16 = ta; b16 = tb_v; ci16 = tci; start16 = 1'b1;
        tick();
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
        done_at = -1; done_cnt = 0; s_done = '0; co_done = 1'b0; ovf_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done16) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i; s_done = s16; co_done = co16;
`ifdef SUMADOR_OVF_EN
                    ovf_done = ovf16;
`endif
                end
            end
            tick();
        end
        $display("[TB] txn16 a=%h b=%h ci=%0d -> co=%0d s=%h ovf=%0d (exp %h ovf %0d)",
                 ta, tb_v, tci, co_done, s_done, ovf_done, exp_sum, eovf);
        tests_run++;
        if ({co_done, s_done} !== exp_sum) begin
            tests_failed++; $display("FAIL w16_sum: got %h expected %h", {co_done, s_done}, exp_sum);
        end
        tests_run++;
        if (done_at != 4 || done_cnt != 1) begin
            tests_failed++;
            $display("FAIL w16_done: done_at=%0d dones=%0d expected 4 1", done_at, done_cnt);
        end
`ifdef SUMADOR_OVF_EN
        tests_run++;
        if (ovf_done !== eovf) begin
            tests_failed++; $display("FAIL w16_ovf: got %0d expected %0d", ovf_done, eovf);
        end
`endif
    endtask

    task automatic test_width16();
        run16(16'hFFFF, 16'h0001, 1'b0);
        run16(16'h8000, 16'h8000, 1'b1);
        run16(16'h1234, 16'h4321, 1'b1);
        run16(16'h7FFF, 16'h0000, 1'b1);
        for (int n = 0; n < 200; n++) begin
            run16(16'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_mid_run();
        test_width1();
        test_width16();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
